// File: rtl/fp_rnd_pipe_if.sv
// Handshake bundle between the FMA rounding producer and the result consumer.
// The producer side (master) drives en and the unrounded record; the pipe (slave) returns the packed result.
interface fp_rnd_pipe_if;
  logic        en;
  logic        in_valid;
  logic        in_sig;
  logic [13:0] in_expo;
  logic [53:0] in_mant;
  logic [1:0]  in_rema;
  logic [1:0]  in_fmt;
  logic [2:0]  in_rm;
  logic [2:0]  in_grs;
  logic        in_snan;
  logic        in_qnan;
  logic        in_dbz;
  logic        in_inf;
  logic        in_zero;
  logic        out_valid;
  logic [63:0] out_result;
  logic [4:0]  out_flags;

  modport master (
    output en, in_valid, in_sig, in_expo, in_mant, in_rema, in_fmt, in_rm, in_grs,
    output in_snan, in_qnan, in_dbz, in_inf, in_zero,
    input  out_valid, out_result, out_flags
  );

  modport slave (
    input  en, in_valid, in_sig, in_expo, in_mant, in_rema, in_fmt, in_rm, in_grs,
    input  in_snan, in_qnan, in_dbz, in_inf, in_zero,
    output out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_rnd_pipe.sv
// IEEE-754 round-and-pack: stage 1 rounds the mantissa, stage 2 resolves overflow/specials and packs.
// Two enabled cycles of latency; en=0 freezes every stage, there is no ready back to the producer.
module fp_rnd_pipe (
  input  logic          clock,
  input  logic          reset,
  fp_rnd_pipe_if.slave  s_if
);
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  logic        w_fmt64;
  logic [2:0]  w_rm;
  logic        w_nx;
  logic        w_inc;
  logic [53:0] w_mant;
  logic [53:0] w_sum;
  logic        w_carry;
  logic        w_hidden;
  logic [14:0] w_exp;

  assign w_fmt64 = (s_if.in_fmt == 2'd1);
  assign w_rm    = (s_if.in_rm > RM_RMM) ? RM_RNE : s_if.in_rm;
  assign w_nx    = |s_if.in_grs;
  assign w_mant  = w_fmt64 ? {1'b0, s_if.in_mant[52:0]} : {30'd0, s_if.in_mant[23:0]};

  always_comb begin
    w_inc = 1'b0;
    case (w_rm)
      RM_RNE:  w_inc = s_if.in_grs[2] & (s_if.in_grs[1] | s_if.in_grs[0] | w_mant[0]);
      RM_RDN:  w_inc = s_if.in_sig & w_nx;
      RM_RUP:  w_inc = ~s_if.in_sig & w_nx;
      RM_RMM:  w_inc = s_if.in_grs[2];
      default: w_inc = 1'b0;
    endcase
  end

  // A carry leaves exactly a power of two, so the low fraction bits are already zero.
  assign w_sum    = w_mant + {53'd0, w_inc};
  assign w_carry  = w_fmt64 ? w_sum[53] : w_sum[24];
  assign w_hidden = w_fmt64 ? w_sum[52] : w_sum[23];
  assign w_exp    = {1'b0, s_if.in_expo}
                  + {14'd0, w_carry | ((s_if.in_expo == 14'd0) & w_hidden)};

  logic        r_s1_vld;
  logic        r_s1_sig;
  logic        r_s1_fmt64;
  logic [2:0]  r_s1_rm;
  logic [14:0] r_s1_exp;
  logic [51:0] r_s1_frac;
  logic        r_s1_nx;
  logic        r_s1_tiny;
  logic [4:0]  r_s1_spec;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_vld <= 1'b0;
    end else if (s_if.en) begin
      r_s1_vld <= s_if.in_valid;
      if (s_if.in_valid) begin
        r_s1_sig   <= s_if.in_sig;
        r_s1_fmt64 <= w_fmt64;
        r_s1_rm    <= w_rm;
        r_s1_exp   <= w_exp;
        r_s1_frac  <= w_sum[51:0];
        r_s1_nx    <= w_nx;
        r_s1_tiny  <= (s_if.in_expo == 14'd0);
        r_s1_spec  <= {s_if.in_snan, s_if.in_qnan, s_if.in_dbz, s_if.in_inf, s_if.in_zero};
      end
    end
  end

  logic        w_ovf;
  logic        w_to_max;
  logic [10:0] w_exp_all1;
  logic [51:0] w_frac_all1;
  logic [51:0] w_frac_qnan;
  logic        w_o_sig;
  logic [10:0] w_o_exp;
  logic [51:0] w_o_frac;
  logic [4:0]  w_o_flags;
  logic [63:0] w_packed;

  assign w_ovf       = r_s1_fmt64 ? (r_s1_exp >= 15'd2047) : (r_s1_exp >= 15'd255);
  assign w_to_max    = (r_s1_rm == RM_RTZ) | ((r_s1_rm == RM_RDN) & ~r_s1_sig)
                     | ((r_s1_rm == RM_RUP) & r_s1_sig);
  assign w_exp_all1  = r_s1_fmt64 ? 11'h7FF : 11'h0FF;
  assign w_frac_all1 = r_s1_fmt64 ? {52{1'b1}} : {29'd0, {23{1'b1}}};
  assign w_frac_qnan = r_s1_fmt64 ? 52'h8_0000_0000_0000 : 52'h0_0000_0040_0000;

  // Priority: snan > qnan > dbz > inf > zero > rounded value.
  always_comb begin
    w_o_sig   = r_s1_sig;
    w_o_exp   = r_s1_exp[10:0];
    w_o_frac  = r_s1_frac;
    w_o_flags = {3'b000, r_s1_tiny & r_s1_nx, r_s1_nx};
    if (r_s1_spec[4] | r_s1_spec[3]) begin
      w_o_sig   = 1'b0;
      w_o_exp   = w_exp_all1;
      w_o_frac  = w_frac_qnan;
      w_o_flags = r_s1_spec[4] ? 5'b10000 : 5'b00000;
    end else if (r_s1_spec[2] | r_s1_spec[1]) begin
      w_o_exp   = w_exp_all1;
      w_o_frac  = 52'd0;
      w_o_flags = r_s1_spec[2] ? 5'b01000 : 5'b00000;
    end else if (r_s1_spec[0]) begin
      w_o_exp   = 11'd0;
      w_o_frac  = 52'd0;
      w_o_flags = 5'b00000;
    end else if (w_ovf) begin
      w_o_exp   = w_to_max ? (w_exp_all1 - 11'd1) : w_exp_all1;
      w_o_frac  = w_to_max ? w_frac_all1 : 52'd0;
      w_o_flags = 5'b00101;
    end
  end

  assign w_packed = r_s1_fmt64 ? {w_o_sig, w_o_exp, w_o_frac}
                               : {32'hFFFF_FFFF, w_o_sig, w_o_exp[7:0], w_o_frac[22:0]};

  logic        r_out_vld;
  logic [63:0] r_out_res;
  logic [4:0]  r_out_flags;

  // Result and flags only load on a valid record so bubbles keep the last result visible.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_vld   <= 1'b0;
      r_out_res   <= 64'd0;
      r_out_flags <= 5'd0;
    end else if (s_if.en) begin
      r_out_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_out_res   <= w_packed;
        r_out_flags <= w_o_flags;
      end
    end
  end

  assign s_if.out_valid  = r_out_vld;
  assign s_if.out_result = r_out_res;
  assign s_if.out_flags  = r_out_flags;
endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Randomized bench for fp_rnd_pipe: an arithmetic rounding model predicts each result, and a
// single negedge process checks valid timing, held outputs and values against it every cycle.
module tb_fp_rnd_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_rnd_pipe_if bus ();
  fp_rnd_pipe dut (.clock(clk), .reset(rst), .s_if(bus));

  typedef struct {
    bit        sig;
    bit [13:0] expo;
    bit [53:0] mant;
    bit [1:0]  rema;
    bit [1:0]  fmt;
    bit [2:0]  rm;
    bit [2:0]  grs;
    bit [4:0]  sp;   // {snan, qnan, dbz, inf, zero}
  } rec_t;

  typedef struct {
    bit [63:0] res;
    bit [4:0]  flg;
    int        acc;
    bit        lit;
    bit [63:0] lres;
    bit [4:0]  lflg;
    int        id;
  } exp_t;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  rec_t      cur;
  bit        cur_lit = 1'b0;
  bit [63:0] cur_lres;
  bit [4:0]  cur_lflg;
  int        pin_id = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic bit [63:0] pack(input bit is64, input bit s, input longint unsigned e,
                                     input longint unsigned f);
    if (is64) return {s, e[10:0], f[51:0]};
    return {32'hFFFF_FFFF, s, e[7:0], f[22:0]};
  endfunction

  // Reference: value-level IEEE rounding with an unbounded exponent, then range and specials.
  function automatic exp_t model(input rec_t r);
    exp_t o;
    bit is64, nx, up, to_max;
    int p, rmd;
    longint unsigned one, emax, m, m2, e, frac;
    o = '{default: 0};
    one  = 1;
    is64 = (r.fmt == 2'd1);
    p    = is64 ? 52 : 23;
    emax = is64 ? 2047 : 255;
    rmd  = (r.rm > 3'd4) ? 0 : int'(r.rm);
    if (is64) m = 64'(r.mant[52:0]);
    else      m = 64'(r.mant[23:0]);
    nx = |r.grs;
    case (rmd)
      0:       up = r.grs[2] & (r.grs[1] | r.grs[0] | m[0]);
      1:       up = 1'b0;
      2:       up = r.sig & nx;
      3:       up = ~r.sig & nx;
      default: up = r.grs[2];
    endcase
    to_max = (rmd == 1) || (rmd == 2 && !r.sig) || (rmd == 3 && r.sig);
    m2 = m + 64'(up);
    e  = 64'(r.expo);
    if (m2 >= (one << (p + 1)))                e = e + 1;
    else if (r.expo == 0 && m2 >= (one << p))  e = 1;
    frac = m2 & ((one << p) - 1);
    if (r.sp[4]) begin
      o.res = is64 ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000; o.flg = 5'h10;
    end else if (r.sp[3]) begin
      o.res = is64 ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000; o.flg = 5'h00;
    end else if (r.sp[2]) begin
      o.res = pack(is64, r.sig, emax, 0); o.flg = 5'h08;
    end else if (r.sp[1]) begin
      o.res = pack(is64, r.sig, emax, 0); o.flg = 5'h00;
    end else if (r.sp[0]) begin
      o.res = pack(is64, r.sig, 0, 0); o.flg = 5'h00;
    end else if (e >= emax) begin
      o.flg = 5'h05;
      o.res = to_max ? pack(is64, r.sig, emax - 1, (one << p) - 1) : pack(is64, r.sig, emax, 0);
    end else begin
      o.flg = {3'b000, (r.expo == 0) && nx, nx};
      o.res = pack(is64, r.sig, e, frac);
    end
    return o;
  endfunction

  function automatic rec_t mk(input bit s, input int ex, input logic [53:0] m, input bit [1:0] f,
                              input bit [2:0] rm, input bit [2:0] grs, input bit [4:0] sp);
    rec_t r;
    r.sig = s; r.expo = ex[13:0]; r.mant = m; r.rema = 2'd0;
    r.fmt = f; r.rm = rm; r.grs = grs; r.sp = sp;
    return r;
  endfunction

  function automatic rec_t rnd();
    rec_t r;
    int p, emax;
    r.fmt  = 2'($urandom_range(0, 3));
    r.rm   = 3'($urandom_range(0, 7));
    r.sig  = 1'($urandom);
    r.grs  = 3'($urandom);
    r.rema = 2'($urandom);
    r.mant = {22'($urandom), $urandom};
    if ($urandom_range(0, 3) == 0) r.mant = '1;
    p    = (r.fmt == 2'd1) ? 52 : 23;
    emax = (r.fmt == 2'd1) ? 2047 : 255;
    case ($urandom_range(0, 5))
      0:       r.expo = 14'd0;
      1:       r.expo = 14'(emax - 1);
      2:       r.expo = 14'(emax);
      3:       r.expo = 14'($urandom_range(0, 16383));
      default: r.expo = 14'($urandom_range(1, emax - 2));
    endcase
    if (r.expo != 0) r.mant[p] = 1'b1;
    else if ($urandom_range(0, 1) == 1) r.mant[p] = 1'b0;
    r.sp = 5'd0;
    for (int i = 0; i < 5; i++) if ($urandom_range(0, 15) == 0) r.sp[i] = 1'b1;
    return r;
  endfunction

  task automatic drive(input rec_t r);
    cur = r;
    bus.in_sig  = r.sig;  bus.in_expo = r.expo; bus.in_mant = r.mant; bus.in_rema = r.rema;
    bus.in_fmt  = r.fmt;  bus.in_rm   = r.rm;   bus.in_grs  = r.grs;
    bus.in_snan = r.sp[4]; bus.in_qnan = r.sp[3]; bus.in_dbz = r.sp[2];
    bus.in_inf  = r.sp[1]; bus.in_zero = r.sp[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.en = 1'b1;
    repeat (n) step();
  endtask

  task automatic pin(input rec_t r, input logic [63:0] lr, input logic [4:0] lf);
    drive(r);
    pin_id++;
    cur_lit = 1'b1; cur_lres = lr; cur_lflg = lf;
    bus.in_valid = 1'b1; bus.en = 1'b1;
    step();
    cur_lit = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  // Compare process: an item accepted at enabled edge number a is due once a+1 enabled edges passed.
  exp_t      q[$];
  exp_t      e;
  exp_t      mres;
  int        ecnt = 0;
  bit        en_pend = 1'b0;
  bit        rst_pend = 1'b1;
  bit        exp_vld;
  bit [63:0] last_res = 64'd0;
  bit [4:0]  last_flg = 5'd0;

  always @(negedge clk) begin
    if (en_pend && !rst_pend) ecnt++;
    if (rst_pend) begin
      last_res = 64'd0;
      last_flg = 5'd0;
    end
    exp_vld = (q.size() > 0) && (q[0].acc + 1 == ecnt);
    chk("out_valid", 64'(bus.out_valid), 64'(exp_vld));
    if (exp_vld) begin
      chk("result", bus.out_result, q[0].res);
      chk("flags", 64'(bus.out_flags), 64'(q[0].flg));
      if (q[0].lit) begin
        chk($sformatf("pin%0d result", q[0].id), bus.out_result, q[0].lres);
        chk($sformatf("pin%0d flags", q[0].id), 64'(bus.out_flags), 64'(q[0].lflg));
      end
    end else begin
      chk("held result", bus.out_result, last_res);
      chk("held flags", 64'(bus.out_flags), 64'(last_flg));
    end
    if (rst) begin
      q.delete();
    end else begin
      if (exp_vld && bus.en) begin
        e = q.pop_front();
        last_res = e.res;
        last_flg = e.flg;
      end
      if (bus.en && bus.in_valid) begin
        mres = model(cur);
        mres.acc = ecnt + 1;
        mres.lit = cur_lit; mres.lres = cur_lres; mres.lflg = cur_lflg; mres.id = pin_id;
        if (cur_lit) begin
          chk($sformatf("pin%0d model result", pin_id), mres.res, cur_lres);
          chk($sformatf("pin%0d model flags", pin_id), 64'(mres.flg), 64'(cur_lflg));
        end
        q.push_back(mres);
      end
    end
    en_pend  = bus.en;
    rst_pend = rst;
    if (done) begin
      chk("drain", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  localparam logic [53:0] ONES53 = 54'h1F_FFFF_FFFF_FFFF;

  initial begin
    bus.en = 1'b0;
    bus.in_valid = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    bus.en = 1'b1;

    pin(mk(0, 127, 54'h80_0000, 0, 0, 3'b000, 0), 64'hFFFF_FFFF_3F80_0000, 5'h00);
    pin(mk(0, 1023, ONES53, 1, 0, 3'b100, 0),     64'h4000_0000_0000_0000, 5'h01);
    pin(mk(0, 2046, ONES53, 1, 0, 3'b110, 0),     64'h7FF0_0000_0000_0000, 5'h05);
    pin(mk(0, 2046, ONES53, 1, 1, 3'b110, 0),     64'h7FEF_FFFF_FFFF_FFFF, 5'h01);
    pin(mk(1, 2046, ONES53, 1, 3, 3'b110, 0),     64'hFFEF_FFFF_FFFF_FFFF, 5'h01);
    pin(mk(0, 2047, 54'h10_0000_0000_0000, 1, 1, 3'b000, 0), 64'h7FEF_FFFF_FFFF_FFFF, 5'h05);
    pin(mk(0, 127, 54'h80_0000, 0, 0, 3'b000, 5'b10000), 64'hFFFF_FFFF_7FC0_0000, 5'h10);
    pin(mk(1, 100, 54'h10_0000_0000_0000, 1, 0, 3'b000, 5'b00100), 64'hFFF0_0000_0000_0000, 5'h08);
    pin(mk(1, 100, 54'h10_0000_0000_0000, 1, 0, 3'b000, 5'b00001), 64'h8000_0000_0000_0000, 5'h00);
    pin(mk(0, 0, 54'h7F_FFFF, 0, 0, 3'b100, 0),   64'hFFFF_FFFF_0080_0000, 5'h03);
    pin(mk(0, 5, 54'h10_0000_0000_0000, 1, 0, 3'b000, 5'b10110), 64'h7FF8_0000_0000_0000, 5'h10);
    pin(mk(0, 254, 54'hFF_FFFF, 0, 0, 3'b100, 0), 64'hFFFF_FFFF_7F80_0000, 5'h05);
    pin(mk(0, 127, 54'h80_0001, 0, 7, 3'b100, 0), 64'hFFFF_FFFF_3F80_0002, 5'h01);
    pin(mk(0, 127, 54'h80_0000, 0, 4, 3'b100, 0), 64'hFFFF_FFFF_3F80_0001, 5'h01);
    idle(4);

    // A, B, C back to back with en dropped for three cycles after B is accepted.
    bus.en = 1'b1; bus.in_valid = 1'b1;
    drive(mk(0, 130, 54'hA0_0000, 0, 0, 3'b000, 0)); step();
    drive(mk(1, 1030, 54'h18_0000_0000_0000, 1, 0, 3'b001, 0)); step();
    drive(mk(0, 140, 54'hC0_0001, 0, 3, 3'b010, 0));
    bus.en = 1'b0;
    repeat (3) step();
    bus.en = 1'b1; step();
    idle(4);

    // Reset while B and C are in flight; nothing stale may emerge afterwards.
    bus.in_valid = 1'b1;
    drive(mk(0, 130, 54'hA0_0000, 0, 0, 3'b000, 0)); step();
    drive(mk(1, 1030, 54'h18_0000_0000_0000, 1, 0, 3'b001, 0)); step();
    drive(mk(0, 140, 54'hC0_0001, 0, 3, 3'b010, 0)); step();
    rst = 1'b1; bus.en = 1'b0;
    drive(mk(0, 150, 54'hE0_0000, 0, 0, 3'b000, 0)); step();
    rst = 1'b0;
    idle(5);

    for (int i = 0; i < 2500; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      bus.en       = ($urandom_range(0, 7) != 0);
      bus.in_valid = ($urandom_range(0, 4) != 0);
      drive(rnd());
      step();
    end
    rst = 1'b0;
    idle(6);
    done = 1'b1;
  end
endmodule
